ht_cmd_arbiter: RTL and testbench

// - Shares one hash_table_top command/result port pair among CLIENTS requesters.
// - Round-robin arbitration of client commands into one registered output command stage.
// - Records the winner's index in an in-order tag FIFO. Results (in order from the table) route back by FIFO head.
// - Sits between client logic (lookup engines, CPU mailbox) and ht_cmd_in / ht_res_out.

---
 rtl/ht_cmd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ht_cmd_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_cmd_arbiter.sv
// rtl/ht_cmd_arbiter.sv - round-robin command arbiter with in-order result routing (optional HT_ARB_STATS_EN per-client stats)
module ht_cmd_arbiter #(
  parameter int CLIENTS     = 4,
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 16,
  parameter int RES_W       = 64,
  parameter int TAG_DEPTH   = 8,
  localparam int CMD_W      = 2 + KEY_WIDTH + VALUE_WIDTH,
  localparam int CID_W      = (CLIENTS > 1) ? $clog2(CLIENTS) : 1,
  localparam int CNT_W      = $clog2(TAG_DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CLIENTS-1:0]       cl_cmd_valid_i,
  input  logic [CLIENTS*CMD_W-1:0] cl_cmd_i,
  output logic [CLIENTS-1:0]       cl_cmd_ready_o,
  output logic                     cmd_valid_o,
  output logic [CMD_W-1:0]         cmd_o,
  input  logic                     cmd_ready_i,
  input  logic                     res_valid_i,
  input  logic [RES_W-1:0]         res_i,
  output logic                     res_ready_o,
  output logic [CLIENTS-1:0]       cl_res_valid_o,
  output logic [RES_W-1:0]         cl_res_o,
  input  logic [CLIENTS-1:0]       cl_res_ready_i,
  output logic [CNT_W-1:0]         outstanding_o,
  output logic                     orphan_o
`ifdef HT_ARB_STATS_EN
  ,
  output logic [CLIENTS*32-1:0]    stat_cnt_o
`endif
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam logic [CLIENTS-1:0] ONE_HOT0 = {{(CLIENTS-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state;
  logic [CID_W-1:0]   rr_ptr;
  logic [CID_W-1:0]   cmd_cid;

  logic [CID_W-1:0]   tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CID_W-1:0]   head;
  logic               fifo_empty;

  logic               out_hs;
  logic               admit;
  logic               grant_found;
  logic               grant_en;
  logic [CID_W-1:0]   grant_idx;
  logic [CMD_W-1:0]   grant_cmd;
  logic               push;
  logic               pop;
  int                 cand;

  assign out_hs = cmd_valid_o & cmd_ready_i;

  // The held command still needs a tag slot, so it counts against the budget.
  assign admit = ((int'(count) + int'(cmd_valid_o)) < TAG_DEPTH) && (!cmd_valid_o || out_hs);

  // Round-robin search: first valid client strictly after the last winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 1; off <= CLIENTS; off++) begin
      cand = int'(rr_ptr) + off;
      if (cand >= CLIENTS) begin
        cand = cand - CLIENTS;
      end
      if (!grant_found && cl_cmd_valid_i[cand[CID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[CID_W-1:0];
      end
    end
  end

  assign grant_en       = admit & grant_found;
  assign grant_cmd      = cl_cmd_i[int'(grant_idx)*CMD_W +: CMD_W];
  assign cl_cmd_ready_o = grant_en ? (ONE_HOT0 << grant_idx) : '0;

  // Output stage: IDLE loads on grant, HOLD keeps the command stable until handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cmd_valid_o <= 1'b0;
      cmd_o       <= '0;
      cmd_cid     <= '0;
      rr_ptr      <= CID_W'(CLIENTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            state       <= HOLD;
            cmd_valid_o <= 1'b1;
            cmd_o       <= grant_cmd;
            cmd_cid     <= grant_idx;
            rr_ptr      <= grant_idx;
          end
        end
        HOLD: begin
          if (out_hs) begin
            if (grant_en) begin
              cmd_o       <= grant_cmd;
              cmd_cid     <= grant_idx;
              rr_ptr      <= grant_idx;
            end else begin
              state       <= IDLE;
              cmd_valid_o <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign fifo_empty     = (count == '0);
  assign head           = tag_mem[rd_ptr];
  assign res_ready_o    = fifo_empty | cl_res_ready_i[head];
  assign cl_res_valid_o = (res_valid_i && !fifo_empty) ? (ONE_HOT0 << head) : '0;
  assign cl_res_o       = res_i;
  assign outstanding_o  = count;

  // Tags enter when the table takes the command, not at grant time.
  assign push = out_hs;
  assign pop  = res_valid_i & res_ready_o & ~fifo_empty;

  // Tag storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem[wr_ptr] <= cmd_cid;
    end
  end

  // Tag FIFO pointers and occupancy; pointers wrap naturally at TAG_DEPTH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for a result with no owner; that result is silently accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      orphan_o <= 1'b0;
    end else if (res_valid_i && fifo_empty) begin
      orphan_o <= 1'b1;
    end
  end

`ifdef HT_ARB_STATS_EN
  // Per-client count of commands actually taken by the table, wrapping at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_cnt_o <= '0;
    end else if (out_hs) begin
      stat_cnt_o[int'(cmd_cid)*32 +: 32] <= stat_cnt_o[int'(cmd_cid)*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// tb/tb_ht_cmd_arbiter.sv - self-checking bench for ht_cmd_arbiter
module tb_ht_cmd_arbiter;

  localparam int CL   = 4;
  localparam int CW   = 50;
  localparam int RW   = 64;
  localparam logic [CW-1:0] C_INS = {2'b01, 32'h0100_0000, 16'h1234};
  localparam logic [CW-1:0] C_A   = {2'b10, 32'hAAAA_0000, 16'h000A};
  localparam logic [CW-1:0] C_B   = {2'b11, 32'hBBBB_0000, 16'h000B};
  localparam logic [CW-1:0] C_C   = {2'b01, 32'hCCCC_0000, 16'h000C};

  logic              clk = 1'b0;
  logic              rst;
  logic [CL-1:0]     cl_cmd_valid;
  logic [CL*CW-1:0]  cl_cmd;
  logic [CL-1:0]     cl_cmd_ready;
  logic              cmd_valid;
  logic [CW-1:0]     cmd;
  logic              cmd_ready;
  logic              res_valid;
  logic [RW-1:0]     res;
  logic              res_ready;
  logic [CL-1:0]     cl_res_valid;
  logic [RW-1:0]     cl_res;
  logic [CL-1:0]     cl_res_ready;
  logic [3:0]        outstanding;
  logic              orphan;
`ifdef HT_ARB_STATS_EN
  logic [CL*32-1:0]  stat_cnt;
`endif

  int total = 0;
  int bad   = 0;

  ht_cmd_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cl_cmd_valid_i (cl_cmd_valid),
    .cl_cmd_i       (cl_cmd),
    .cl_cmd_ready_o (cl_cmd_ready),
    .cmd_valid_o    (cmd_valid),
    .cmd_o          (cmd),
    .cmd_ready_i    (cmd_ready),
    .res_valid_i    (res_valid),
    .res_i          (res),
    .res_ready_o    (res_ready),
    .cl_res_valid_o (cl_res_valid),
    .cl_res_o       (cl_res),
    .cl_res_ready_i (cl_res_ready),
    .outstanding_o  (outstanding),
    .orphan_o       (orphan)
`ifdef HT_ARB_STATS_EN
    ,
    .stat_cnt_o     (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of owner ids plus the one held command.
  bit            m_cv;
  logic [CW-1:0] m_cmd;
  int            m_cid;
  int            m_rr;
  int            q[$];
  bit            m_orphan;
  bit            e_hs;
  bit            e_admit;
  int            e_win;
  logic [CL-1:0] e_ready;
  logic [CL-1:0] e_rvalid;
  bit            e_rready;

  always @(negedge clk) begin
    if (rst) begin
      m_cv     = 1'b0;
      m_cmd    = '0;
      m_cid    = 0;
      m_rr     = CL - 1;
      m_orphan = 1'b0;
      q.delete();
    end else begin
      e_hs    = m_cv && cmd_ready;
      e_admit = (q.size() + int'(m_cv) < 8) && (!m_cv || e_hs);
      e_win   = -1;
      for (int k = 1; k <= CL; k++) begin
        if (e_win < 0 && cl_cmd_valid[(m_rr + k) % CL]) e_win = (m_rr + k) % CL;
      end
      e_ready = (e_admit && e_win >= 0) ? (4'b0001 << e_win) : 4'b0000;
      e_rready = (q.size() == 0) ? 1'b1 : cl_res_ready[q[0]];
      e_rvalid = (res_valid && q.size() != 0) ? (4'b0001 << q[0]) : 4'b0000;

      chk("m_cl_cmd_ready", cl_cmd_ready, e_ready);
      chk("m_cmd_valid", cmd_valid, m_cv);
      if (m_cv) chk("m_cmd", cmd, m_cmd);
      chk("m_outstanding", outstanding, q.size());
      chk("m_orphan", orphan, m_orphan);
      chk("m_res_ready", res_ready, e_rready);
      chk("m_cl_res_valid", cl_res_valid, e_rvalid);
      chk("m_cl_res", cl_res, res);

      if (res_valid && q.size() == 0) m_orphan = 1'b1;
      if (res_valid && q.size() != 0 && cl_res_ready[q[0]]) void'(q.pop_front());
      if (e_hs) q.push_back(m_cid);
      if (e_ready != 0) begin
        m_cv  = 1'b1;
        m_cmd = cl_cmd[e_win*CW +: CW];
        m_cid = e_win;
        m_rr  = e_win;
      end else if (e_hs) begin
        m_cv = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    cl_cmd_valid = '0;
    cmd_ready    = 1'b0;
    res_valid    = 1'b0;
    res          = '0;
    cl_res_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int drain_ord[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    cl_cmd = '0;
    do_reset();
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_outstanding", outstanding, 4'd0);
    chk("rst_orphan", orphan, 1'b0);
    chk("rst_cl_cmd_ready", cl_cmd_ready, 4'b0000);

    // single client 2 insert
    cl_cmd[2*CW +: CW] = C_INS;
    cl_cmd_valid = 4'b0100;
    cmd_ready = 1'b1;
    #1 chk("t1_grant", cl_cmd_ready, 4'b0100);
    step();
    cl_cmd_valid = '0;
    #1 chk("t1_cmd_valid", cmd_valid, 1'b1);
    chk("t1_cmd", cmd, C_INS);
    step();
    #1 chk("t1_outstanding", outstanding, 4'd1);
    chk("t1_idle", cmd_valid, 1'b0);
    res_valid = 1'b1;
    res = 64'hDEAD_BEEF_0000_0002;
    #1 chk("t1_route", cl_res_valid, 4'b0100);
    chk("t1_res_ready", res_ready, 1'b1);
    step();
    res_valid = 1'b0;
    #1 chk("t1_drained", outstanding, 4'd0);

    // fairness and tag full
    do_reset();
    for (int i = 0; i < CL; i++) cl_cmd[i*CW +: CW] = {2'b00, 32'h0A00_0000 + 32'(i), 16'(i)};
    cl_cmd_valid = 4'hF;
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("fair_grant", cl_cmd_ready, 4'b0001 << (i % 4));
      step();
    end
    #1 chk("full_held", cmd_valid, 1'b1);
    chk("full_nogrant0", cl_cmd_ready, 4'b0000);
    step();
    #1 chk("full_outstanding", outstanding, 4'd8);
    chk("full_nogrant1", cl_cmd_ready, 4'b0000);
    res_valid = 1'b1;
    res = 64'h1;
    #1 chk("full_pop_route", cl_res_valid, 4'b0001);
    step();
    res_valid = 1'b0;
    #1 chk("refill_outstanding", outstanding, 4'd7);
    chk("refill_grant", cl_cmd_ready, 4'b0001);
    step();
    cl_cmd_valid = '0;
    res_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      res = 64'(i + 16);
      #1 chk("drain_route", cl_res_valid, 4'b0001 << drain_ord[i]);
      step();
    end
    res_valid = 1'b0;
    #1 chk("drain_empty", outstanding, 4'd0);

    // backpressure
    do_reset();
    cl_cmd[0*CW +: CW] = C_A;
    cl_cmd[1*CW +: CW] = C_B;
    cl_cmd_valid = 4'b0011;
    cmd_ready = 1'b0;
    #1 chk("bp_grant0", cl_cmd_ready, 4'b0001);
    step();
    cl_cmd_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_hold_cmd", cmd, C_A);
      chk("bp_no_grant", cl_cmd_ready, 4'b0000);
      step();
    end
    cmd_ready = 1'b1;
    #1 chk("bp_rel_grant", cl_cmd_ready, 4'b0010);
    step();
    cl_cmd_valid = '0;
    #1 chk("bp_cmd_b", cmd, C_B);
    step();
    #1 chk("bp_outstanding", outstanding, 4'd2);

    // result stall with client 1 at the head
    res_valid = 1'b1;
    res = 64'hA0;
    #1 chk("st_pop0", cl_res_valid, 4'b0001);
    step();
    cl_res_ready = 4'b1101;
    cl_cmd[3*CW +: CW] = C_C;
    #1 chk("st_ready0", res_ready, 1'b0);
    chk("st_route", cl_res_valid, 4'b0010);
    step();
    cl_cmd_valid = 4'b1000;
    #1 chk("st_ready1", res_ready, 1'b0);
    chk("st_grant", cl_cmd_ready, 4'b1000);
    step();
    #1 chk("st_ready2", res_ready, 1'b0);
    chk("st_count", outstanding, 4'd1);
    step();
    cl_cmd_valid = '0;
    cl_res_ready = 4'hF;
    #1 chk("st_push_only", outstanding, 4'd2);
    chk("st_release", res_ready, 1'b1);
    step();
    #1 chk("st_pushpop_const", outstanding, 4'd2);
    chk("st_route3a", cl_res_valid, 4'b1000);
    step();
    #1 chk("st_route3b", cl_res_valid, 4'b1000);
    step();
    res_valid = 1'b0;
    #1 chk("st_empty", outstanding, 4'd0);

    // orphan result
    res_valid = 1'b1;
    res = 64'hBAD;
    #1 chk("orph_ready", res_ready, 1'b1);
    chk("orph_no_route", cl_res_valid, 4'b0000);
    step();
    res_valid = 1'b0;
    #1 chk("orph_set", orphan, 1'b1);
    step();
    #1 chk("orph_sticky", orphan, 1'b1);
    #1 rst = 1'b1;
    #1 chk("orph_async_clear", orphan, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
